// File: rtl/clken_channel_gen_pkg.sv
// Shared types and constants for the clock-enable / reset-sequencing generator.
// Holds the sequencer state encoding, the lock-loss filter length and counter width helpers.
package clken_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } state_e;

    // Consecutive low cycles of the synchronised lock before it counts as lost.
    localparam int unsigned LOCK_FILTER_LEN = 4;

    // Bits needed to count 0..n-1; never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/clken_channel_gen_accum.sv
// One channel's phase accumulator: loads its initial phase while held in reset,
// otherwise adds the increment every cycle and registers the carry as the enable pulse.
module clken_accum #(
    parameter int unsigned ACC_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_i,
    input  logic             kill_i,
    input  logic [ACC_W-1:0] inc_i,
    input  logic [ACC_W-1:0] phase_i,
    output logic             en_o
);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic             en_q, en_d;
    logic [ACC_W:0]   sum;

    assign sum = {1'b0, acc_q} + {1'b0, inc_i};

    // kill_i lets the enable drop on the same edge the channel re-enters reset.
    always_comb begin
        acc_d = sum[ACC_W-1:0];
        en_d  = sum[ACC_W];
        if (load_i) begin
            acc_d = phase_i;
            en_d  = 1'b0;
        end
        if (kill_i) begin
            en_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
            en_q  <= 1'b0;
        end else begin
            acc_q <= acc_d;
            en_q  <= en_d;
        end
    end

    assign en_o = en_q;

endmodule

// File: rtl/clken_channel_gen.sv
// Lock-qualified reset sequencer with per-channel fractional-rate clock enables.
// Define CLKEN_LOCK_FILTER_EN to ignore synchronised lock dropouts shorter than LOCK_FILTER_LEN cycles.
module clken_channel_gen
    import clken_pkg::*;
#(
    parameter int unsigned CHANNELS  = 4,
    parameter int unsigned ACC_W     = 16,
    parameter int unsigned LOCK_HOLD = 1024,
    parameter int unsigned STAGGER   = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      pll_locked,
    input  logic [CHANNELS*ACC_W-1:0] inc,
    input  logic [CHANNELS*ACC_W-1:0] phase,
    output logic [CHANNELS-1:0]       rst_out,
    output logic [CHANNELS-1:0]       en_out,
    output logic                      ready
);

    localparam int unsigned HOLD_W = cnt_w(LOCK_HOLD);
    localparam int unsigned STAG_W = cnt_w(STAGGER);
    localparam int unsigned IDX_W  = cnt_w(CHANNELS);
    localparam int unsigned CNT_W  = (HOLD_W > STAG_W) ? HOLD_W : STAG_W;

    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(LOCK_HOLD - 1);
    localparam logic [CNT_W-1:0] STAG_LAST  = CNT_W'(STAGGER - 1);
    localparam logic [IDX_W-1:0] CHAN_LAST  = IDX_W'(CHANNELS - 1);

    logic [1:0]          sync_q;
    logic                lock_s;
    logic                lock_loss;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [CHANNELS-1:0] rst_q, rst_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], pll_locked};
        end
    end

    assign lock_s = sync_q[1];

`ifdef CLKEN_LOCK_FILTER_EN
    localparam int unsigned FLT_W = cnt_w(LOCK_FILTER_LEN);
    localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(LOCK_FILTER_LEN - 1);

    logic [FLT_W-1:0] flt_q, flt_d;

    // Saturating count of consecutive low cycles; the next low cycle after saturation is a loss.
    always_comb begin
        flt_d = flt_q;
        if (lock_s) begin
            flt_d = '0;
        end else if (flt_q != FLT_LAST) begin
            flt_d = flt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            flt_q <= '0;
        end else begin
            flt_q <= flt_d;
        end
    end

    assign lock_loss = !lock_s && (flt_q == FLT_LAST);
`else
    assign lock_loss = !lock_s;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rst_d   = rst_q;

        unique case (state_q)
            WAIT_LOCK: begin
                cnt_d = '0;
                idx_d = '0;
                rst_d = '1;
                if (lock_s) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d  = RELEASE;
                    cnt_d    = '0;
                    idx_d    = '0;
                    rst_d[0] = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RELEASE: begin
                // The last channel was released on the previous step; one more edge to RUN.
                if (idx_q == CHAN_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else if (cnt_q == STAG_LAST) begin
                    cnt_d = '0;
                    idx_d = idx_q + 1'b1;
                    for (int c = 0; c < int'(CHANNELS); c++) begin
                        if (IDX_W'(c) == idx_d) begin
                            rst_d[c] = 1'b0;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RUN: begin
                cnt_d = '0;
            end
            default: begin
                state_d = WAIT_LOCK;
            end
        endcase

        // Lock loss overrides any release step scheduled for the same edge.
        if ((state_q != WAIT_LOCK) && lock_loss) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
            idx_d   = '0;
            rst_d   = '1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
            idx_q   <= '0;
            rst_q   <= '1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rst_q   <= rst_d;
        end
    end

    assign rst_out = rst_q;
    assign ready   = (state_q == RUN);

    for (genvar g = 0; g < int'(CHANNELS); g++) begin : g_ch
        clken_accum #(
            .ACC_W (ACC_W)
        ) u_accum (
            .clock   (clock),
            .reset   (reset),
            .load_i  (rst_q[g]),
            .kill_i  (rst_d[g]),
            .inc_i   (inc[g*ACC_W +: ACC_W]),
            .phase_i (phase[g*ACC_W +: ACC_W]),
            .en_o    (en_out[g])
        );
    end

endmodule

// File: tb/tb_clken_channel_gen.sv
// Self-checking bench for clken_channel_gen: a timeline model predicts every cycle's
// rst_out/en_out/ready from hold-entry edges and accumulator arithmetic; a monitor compares.
module tb_clken_channel_gen;

    localparam int CH  = 4;
    localparam int AW  = 8;
    localparam int LH  = 8;
    localparam int ST  = 4;
    localparam int OW  = 2*CH + 1;
    localparam int INF = 1 << 30;
`ifdef CLKEN_LOCK_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic               pll_locked = 1'b1;
    logic [CH*AW-1:0]   inc = '0;
    logic [CH*AW-1:0]   phase = '0;
    logic [CH-1:0]      rst_out;
    logic [CH-1:0]      en_out;
    logic               ready;

    clken_channel_gen #(
        .CHANNELS  (CH),
        .ACC_W     (AW),
        .LOCK_HOLD (LH),
        .STAGGER   (ST)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .pll_locked (pll_locked),
        .inc        (inc),
        .phase      (phase),
        .rst_out    (rst_out),
        .en_out     (en_out),
        .ready      (ready)
    );

    always #5 clock = ~clock;

    // ---------------- reference model state ----------------
    int unsigned  inc_m [CH];
    int unsigned  phase_m [CH];
    int           cyc = 0;
    int           hold_e = INF;
    int           sw_e = INF;
    int           sw_hold = INF;
    bit           rst_active = 1'b1;

    logic [OW-1:0] exp_q[$];
    int            exp_c[$];
    int            checks = 0;
    int            failures = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    // Expected {rst_out, en_out, ready} just after edge c, from the release timeline
    // and the carry-out count of phase + k*inc.
    function automatic logic [OW-1:0] expect_at(input int c);
        logic [CH-1:0] r;
        logic [CH-1:0] e;
        logic          rd;
        longint        rel, k, a, b;
        r  = '1;
        e  = '0;
        rd = 1'b0;
        if (!rst_active) begin
            for (int i = 0; i < CH; i++) begin
                rel = longint'(hold_e) + LH + i*ST;
                if (c >= rel) begin
                    r[i] = 1'b0;
                    if (c > rel) begin
                        k = c - rel;
                        a = (longint'(phase_m[i]) + k*longint'(inc_m[i])) >>> AW;
                        b = (longint'(phase_m[i]) + (k-1)*longint'(inc_m[i])) >>> AW;
                        e[i] = (a != b);
                    end
                end
            end
            rd = (longint'(c) >= longint'(hold_e) + LH + (CH-1)*ST + 1);
        end
        return {r, e, rd};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clock);
        cyc++;
        if (cyc == sw_e) begin
            hold_e = sw_hold;
            sw_e   = INF;
        end
        exp_q.push_back(expect_at(cyc));
        exp_c.push_back(cyc);
        #1;
    endtask

    task automatic set_cfg(input bit fixed);
        for (int i = 0; i < CH; i++) begin
            inc_m[i]   = $urandom_range(0, 255);
            phase_m[i] = $urandom_range(0, 255);
        end
        if (fixed) begin
            inc_m[0] = 32'h40; phase_m[0] = 32'hC0;
            inc_m[1] = 32'h00;
            inc_m[2] = 32'h55;
        end
        for (int i = 0; i < CH; i++) begin
            inc[i*AW +: AW]   = inc_m[i][AW-1:0];
            phase[i*AW +: AW] = phase_m[i][AW-1:0];
        end
    endtask

    // Called just after an edge; the next edge is t0, HOLD is entered at t0+2.
    task automatic release_reset();
        reset      = 1'b0;
        rst_active = 1'b0;
        hold_e     = cyc + 3;
        sw_e       = INF;
    endtask

    task automatic async_reset(input string name);
        @(negedge clock);
        #1;
        reset      = 1'b1;
        rst_active = 1'b1;
        #1;
        check(name, {rst_out, en_out, ready}, {{CH{1'b1}}, {CH{1'b0}}, 1'b0});
    endtask

    // Drive pll_locked low for len edges starting after edge d; schedule the expected restart.
    task automatic drop(input int len);
        int d;
        d = cyc;
        if (!FILT || len >= 4) begin
            sw_e    = d + (FILT ? 6 : 3);
            sw_hold = d + len + 3;
        end
        pll_locked = 1'b0;
        repeat (len) step();
        pll_locked = 1'b1;
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [OW-1:0] e;
        int            c;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                c = exp_c.pop_front();
                check($sformatf("outputs@%0d", c), {rst_out, en_out, ready}, e);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int t0, rise, fall0, fall3, n0, n1, n2, tgt;
        set_cfg(1'b1);
        repeat (5) step();
        release_reset();
        t0    = cyc + 1;
        rise  = -1;
        fall0 = -1;
        fall3 = -1;
        for (int n = 0; n < 100 && rise < 0; n++) begin
            step();
            if (fall0 < 0 && !rst_out[0]) fall0 = cyc;
            if (fall3 < 0 && !rst_out[3]) fall3 = cyc;
            if (ready) rise = cyc;
        end
        check("rst0_fall", fall0, t0 + LH + 2);
        check("rst3_fall", fall3, t0 + LH + 2 + 3*ST);
        check("ready_rise", rise, t0 + LH + 3 + (CH-1)*ST);

        n0 = 0; n1 = 0; n2 = 0;
        repeat (256) begin
            step();
            n0 += int'(en_out[0]);
            n1 += int'(en_out[1]);
            n2 += int'(en_out[2]);
        end
        check("ch0_pulses", n0, 64);
        check("ch1_pulses", n1, 0);
        check("ch2_pulses", n2, 85);

        // Single-cycle dropout while running.
        repeat (10) step();
        drop(1);
        repeat (LH + CH*ST + 20) step();

        async_reset("areset_run");
        set_cfg(1'b0);
        repeat (3) step();
        release_reset();

        // Dropout timed so the loss lands on channel 2's release edge.
        tgt = hold_e + 13 - (FILT ? 3 : 0);
        while (cyc < tgt) step();
        drop(6);
        repeat (LH + CH*ST + 30) step();

        // Async reset in HOLD of a fresh attempt.
        async_reset("areset_pre");
        repeat (2) step();
        release_reset();
        while (cyc < hold_e + 3) step();
        async_reset("areset_hold");
        set_cfg(1'b0);
        repeat (2) step();
        release_reset();
        repeat (LH + CH*ST + 10) step();

        for (int it = 0; it < 8; it++) begin
            repeat ($urandom_range(5, 40)) step();
            drop($urandom_range(1, 7));
            repeat (LH + CH*ST + 15) step();
            if (it % 2 == 1) begin
                async_reset("areset_rand");
                set_cfg(1'b0);
                repeat (2) step();
                release_reset();
                repeat (LH + CH*ST + 10) step();
            end
        end

        step();
        @(negedge clock);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
